// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: handshake, operand/result and multiplier-cell bundle for mul_seq_ctrl
// slave  = controller view: takes requests/products, drives ready/result/cell operands
// master = environment view: issues requests, consumes results, hosts the multiplier cell
interface mul_seq_ctrl_if;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_en;
  logic [31:0] mul_p;
  modport slave (
    input  start_valid, op, src1, src2, flush, result_ready, mul_p,
    output start_ready, result_valid, result, mul_a, mul_b, mul_en
  );
  modport master (
    output start_valid, op, src1, src2, flush, result_ready, mul_p,
    input  start_ready, result_valid, result, mul_a, mul_b, mul_en
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: 32x32 multiply sequencer over a shared registered 16x16 unsigned cell
// clk/reset: rising-edge clock, async active-high reset
// bus.start_*/op/src1/src2: request handshake; bus.flush: abort; bus.result_*: result handshake
// bus.mul_a/mul_b/mul_en/mul_p: multiplier cell operands, clock enable and product
module mul_seq_ctrl #(
  parameter int MUL_LAT = 1
) (
  input logic clk,
  input logic reset,
  mul_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, CORR, DONE} state_t;
  localparam logic [1:0] LAT = 2'(MUL_LAT);
  state_t state, state_d;
  logic [1:0] op_q, k;
  logic [31:0] a, b, res, hi_c;
  logic [63:0] acc, prod;
  // tag = {valid, shift code}; iss_tag rides with the registered operands, tag_pipe tracks the cell latency
  logic [2:0] iss_tag;
  logic [MUL_LAT-1:0][2:0] tag_pipe;
  logic is_mul, fl, exit_v;
  logic [1:0] last_k;
  assign is_mul = op_q == 2'b00;
  assign last_k = is_mul ? 2'd2 : 2'd3;
  assign fl = bus.flush && state != IDLE;
  assign exit_v = tag_pipe[MUL_LAT-1][2];
  assign prod = {32'b0, bus.mul_p} << {tag_pipe[MUL_LAT-1][1:0], 4'b0};
  // signed correction of the high word: subtract the other operand for each negative signed operand
  assign hi_c = acc[63:32] - ((op_q[1] && a[31]) ? b : 32'd0) - ((op_q == 2'b10 && b[31]) ? a : 32'd0);
  assign bus.start_ready = state == IDLE;
  assign bus.result_valid = state == DONE;
  assign bus.result = res;
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = bus.start_valid ? ISSUE : IDLE;
      ISSUE:   state_d = k == last_k ? DRAIN : ISSUE;
      DRAIN:   state_d = k == LAT ? CORR : DRAIN;
      CORR:    state_d = DONE;
      DONE:    state_d = bus.result_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (fl) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k <= '0;
      op_q <= '0;
      a <= '0;
      b <= '0;
      acc <= '0;
      res <= '0;
      iss_tag <= '0;
      tag_pipe <= '0;
      bus.mul_a <= '0;
      bus.mul_b <= '0;
      bus.mul_en <= 1'b0;
    end else begin
      k <= state != state_d ? 2'd0 : k + 2'd1;
      iss_tag <= (state == ISSUE && !fl) ? {1'b1, {1'b0, k[1]} + {1'b0, k[0]}} : 3'd0;
      bus.mul_a <= (state == ISSUE && !fl) ? (k[1] ? a[31:16] : a[15:0]) : 16'd0;
      bus.mul_b <= (state == ISSUE && !fl) ? (k[0] ? b[31:16] : b[15:0]) : 16'd0;
      // enable stays high until the last product has left the cell, so deeper cells keep advancing
      bus.mul_en <= !fl && (state == ISSUE || (state == DRAIN && k != LAT));
      tag_pipe[0] <= fl ? 3'd0 : iss_tag;
      for (int i = 1; i < MUL_LAT; i++) tag_pipe[i] <= fl ? 3'd0 : tag_pipe[i-1];
      if (state == IDLE && bus.start_valid) begin
        op_q <= bus.op;
        a <= bus.src1;
        b <= bus.src2;
        acc <= '0;
      end else if (exit_v && !fl) begin
        acc <= acc + prod;
      end else if (state == CORR && !fl) begin
        acc[63:32] <= hi_c;
        res <= is_mul ? acc[31:0] : hi_c;
      end
    end
  end
endmodule
